// File: rtl/mdio_master_param_if.sv
// MDIO master bus bundle: request/response handshake plus the PHY-facing pad signals.
// MDIO_START is a request strobe honoured only while BUSY=0. BUSY stays high through the DATA_RDY pulse. DATA_RDY is a one-clk completion pulse.
interface mdio_master_param_if;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        RD_ERR;
    logic        BUSY;
    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;

    modport master (
        input  MDIO_START, T_DATA, MDIO_IN,
        output RD_DATA, DATA_RDY, RD_ERR, BUSY, MDC, MDIO_OE, MDIO_OUT
    );

    modport slave (
        output MDIO_START, T_DATA, MDIO_IN,
        input  RD_DATA, DATA_RDY, RD_ERR, BUSY, MDC, MDIO_OE, MDIO_OUT
    );
endinterface

// File: rtl/mdio_master_param.sv
// Parametrised MDIO management master for clause-22 and clause-45 frames.
// It sends an optional preamble and then one 32-bit frame, and for reads it captures the turnaround bit and the data.
module mdio_master_param #(
    parameter int DIV     = 4,
    parameter int PRE_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mdio_master_param_if.master m_if,
    output logic [2:0]          o_dbg_state
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_FRAME, S_TA, S_DATA, S_DONE} state_t;

    localparam int             NBITS    = PRE_LEN + 32;
    localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [5:0]     BIT_LAST = 6'(NBITS - 1);

    state_t        r_state, w_next, w_bit_state;
    logic [DW-1:0] r_div;
    logic          r_half;
    logic [5:0]    r_bit;
    logic [31:0]   r_frm;
    logic          r_rd;
    logic [15:0]   r_rx;
    logic          r_ta_bad;
    logic          r_mdc, r_oe, r_out, r_rdy, r_err;
    logic [15:0]   r_rd_data;

    logic          w_accept, w_half_end, w_bit_end, w_last;
    logic [5:0]    w_nbit;
    logic [31:0]   w_src;
    logic          w_src_rd, w_drv_oe, w_drv_out;
    int            w_nb, w_nf, w_cf;

    always_comb begin
        w_accept    = (r_state == S_IDLE) && m_if.MDIO_START;
        w_half_end  = (r_div == DIV_LAST);
        w_bit_end   = w_half_end && r_half;
        w_last      = (r_bit == BIT_LAST);
        // The first bit is computed from the live T_DATA because the latch happens on the same edge.
        w_nbit      = w_accept ? 6'd0 : r_bit + 6'd1;
        w_src       = w_accept ? m_if.T_DATA : r_frm;
        w_src_rd    = w_src[29];
        w_nb        = int'(w_nbit);
        w_nf        = w_nb - PRE_LEN;
        w_cf        = int'(r_bit) - PRE_LEN;
        w_bit_state = S_DATA;
        if (w_nb < PRE_LEN)  w_bit_state = S_PRE;
        else if (w_nf < 14)  w_bit_state = S_FRAME;
        else if (w_nf < 16)  w_bit_state = S_TA;
        w_drv_oe  = 1'b1;
        w_drv_out = 1'b1;
        if (w_bit_state != S_PRE) begin
            w_drv_oe  = !(w_src_rd && (w_nf >= 14));
            w_drv_out = w_drv_oe & w_src[~w_nf[4:0]];
        end
        w_next = r_state;
        case (r_state)
            S_IDLE:                    if (w_accept)  w_next = w_bit_state;
            S_PRE, S_FRAME, S_TA, S_DATA: if (w_bit_end) w_next = w_last ? S_DONE : w_bit_state;
            S_DONE:                    w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_half    <= 1'b0;
            r_bit     <= '0;
            r_frm     <= '0;
            r_rd      <= 1'b0;
            r_rx      <= '0;
            r_ta_bad  <= 1'b0;
            r_mdc     <= 1'b0;
            r_oe      <= 1'b0;
            r_out     <= 1'b0;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rdy <= 1'b0;
            r_err <= 1'b0;
            if (w_accept) begin
                r_frm    <= m_if.T_DATA;
                r_rd     <= m_if.T_DATA[29];
                r_bit    <= '0;
                r_div    <= '0;
                r_half   <= 1'b0;
                r_mdc    <= 1'b0;
                r_oe     <= w_drv_oe;
                r_out    <= w_drv_out;
                r_ta_bad <= 1'b0;
            end else if (r_state != S_IDLE && r_state != S_DONE) begin
                if (!w_half_end) begin
                    r_div <= r_div + DW'(1);
                end else begin
                    r_div <= '0;
                    if (!r_half) begin
                        // This edge raises MDC, so MDIO_IN is sampled here.
                        r_half <= 1'b1;
                        r_mdc  <= 1'b1;
                        if (w_cf == 15) r_ta_bad <= m_if.MDIO_IN;
                        if (r_rd && w_cf >= 16) r_rx <= {r_rx[14:0], m_if.MDIO_IN};
                    end else begin
                        r_half <= 1'b0;
                        r_mdc  <= 1'b0;
                        if (w_last) begin
                            r_oe  <= 1'b0;
                            r_out <= 1'b0;
                            r_rdy <= 1'b1;
                            if (r_rd) begin
                                r_rd_data <= r_rx;
                                r_err     <= r_ta_bad;
                            end
                        end else begin
                            r_bit <= w_nbit;
                            r_oe  <= w_drv_oe;
                            r_out <= w_drv_out;
                        end
                    end
                end
            end
        end
    end

    assign m_if.BUSY     = (r_state != S_IDLE);
    assign m_if.MDC      = r_mdc;
    assign m_if.MDIO_OE  = r_oe;
    assign m_if.MDIO_OUT = r_out;
    assign m_if.DATA_RDY = r_rdy;
    assign m_if.RD_ERR   = r_err;
    assign m_if.RD_DATA  = r_rd_data;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_mdio_master_param.sv
// Bench for mdio_master_param: directed frames on a DIV=4/PRE=32 instance and a DIV=2/PRE=0 instance.
// A PHY model answers reads, and an expected-queue scoreboard checks wire bits, completion data and latency.
module tb_mdio_master_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  mdio_master_param_if ifa ();
  mdio_master_param_if ifb ();
  logic [2:0] dbg_a, dbg_b;
  logic       mdio_in;
  logic       sel;

  mdio_master_param #(.DIV(4), .PRE_LEN(32)) dut_a (.clk(clk), .rst_n(rst_n), .m_if(ifa), .o_dbg_state(dbg_a));
  mdio_master_param #(.DIV(2), .PRE_LEN(0))  dut_b (.clk(clk), .rst_n(rst_n), .m_if(ifb), .o_dbg_state(dbg_b));

  assign ifa.MDIO_IN = mdio_in;
  assign ifb.MDIO_IN = mdio_in;

  logic        m_mdc, m_oe, m_out, m_busy, m_rdy, m_err;
  logic [15:0] m_rd;
  assign m_mdc  = sel ? ifb.MDC      : ifa.MDC;
  assign m_oe   = sel ? ifb.MDIO_OE  : ifa.MDIO_OE;
  assign m_out  = sel ? ifb.MDIO_OUT : ifa.MDIO_OUT;
  assign m_busy = sel ? ifb.BUSY     : ifa.BUSY;
  assign m_rdy  = sel ? ifb.DATA_RDY : ifa.DATA_RDY;
  assign m_err  = sel ? ifb.RD_ERR   : ifa.RD_ERR;
  assign m_rd   = sel ? ifb.RD_DATA  : ifa.RD_DATA;

  // scoreboard: {latency[15:0], rd_err, rd_data[15:0]} per transaction, {oe,out} per wire bit
  logic [32:0] exp_q[$];
  logic [1:0]  bit_q[$];
  int          phy_pre = 0;
  logic [31:0] phy_frame = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic phy_bit(input int i);
    if (i < phy_pre || i >= phy_pre + 32) return 1'b1;
    return phy_frame[5'(31 - (i - phy_pre))];
  endfunction

  // monitor + PHY model
  logic        prev_mdc, prev_busy, fall_chk;
  int          rises, neg_cnt, busy_t0;
  logic [1:0]  exp_bit;
  logic [32:0] exp_rsp;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mdc = 1'b0; prev_busy = 1'b0; fall_chk = 1'b0;
      rises = 0; busy_t0 = 0; mdio_in = 1'b1;
    end else begin
      neg_cnt++;
      if (fall_chk) begin
        chk("idle_after_done", {28'd0, m_busy, m_mdc, m_oe, m_out}, 32'd0);
        fall_chk = 1'b0;
      end
      if (m_busy && !prev_busy) begin
        busy_t0 = neg_cnt;
        rises   = 0;
        mdio_in = phy_bit(0);
      end
      if (m_mdc && !prev_mdc) begin
        if (bit_q.size() == 0) begin
          chk("unexpected_bit", 32'd1, 32'd0);
        end else begin
          exp_bit = bit_q.pop_front();
          chk($sformatf("wire_bit_%0d", rises), {30'd0, m_oe, m_out}, {30'd0, exp_bit});
        end
        rises++;
        mdio_in = phy_bit(rises);
      end
      if (m_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_data_rdy", 32'd1, 32'd0);
        end else begin
          exp_rsp = exp_q.pop_front();
          chk("rd_data", {16'd0, m_rd}, {16'd0, exp_rsp[15:0]});
          chk("rd_err", {31'd0, m_err}, {31'd0, exp_rsp[16]});
          chk("latency", 32'(neg_cnt - busy_t0), {16'd0, exp_rsp[32:17]});
          chk("busy_in_rdy_cycle", {31'd0, m_busy}, 32'd1);
        end
        fall_chk = 1'b1;
      end
      prev_mdc  = m_mdc;
      prev_busy = m_busy;
    end
  end

  task automatic drive_start(input logic v, input logic [31:0] d);
    if (sel) begin ifb.MDIO_START = v; ifb.T_DATA = d; end
    else     begin ifa.MDIO_START = v; ifa.T_DATA = d; end
  endtask

  task automatic issue(input logic [31:0] d, input logic rd, input logic ta2, input logic [15:0] phy_data,
                       input logic [15:0] exp_rd, input logic exp_err, input int pre, input int div);
    for (int i = 0; i < pre; i++) bit_q.push_back(2'b11);
    for (int f = 0; f < 32; f++) begin
      if (rd && f >= 14) bit_q.push_back(2'b00);
      else               bit_q.push_back({1'b1, d[31 - f]});
    end
    exp_q.push_back({16'((pre + 32) * 2 * div), exp_err, exp_rd});
    phy_pre   = pre;
    phy_frame = {14'h3FFF, 1'b1, ta2, phy_data};
    @(negedge clk);
    drive_start(1'b1, d);
    @(negedge clk);
    drive_start(1'b0, ~d);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, {31'd0, n >= 3000}, 32'd0);
    chk({name, "_bits_left"}, 32'(bit_q.size()), 32'd0);
  endtask

  task automatic wait_rises(input string name, input int target, input logic need_mdc);
    int n = 0;
    while (!(rises >= target && (!need_mdc || m_mdc)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, {31'd0, n >= 3000}, 32'd0);
  endtask

  initial begin
    int n;
    sel = 1'b0;
    rst_n = 1'b0;
    neg_cnt = 0;
    ifa.MDIO_START = 1'b0; ifa.T_DATA = '0;
    ifb.MDIO_START = 1'b0; ifb.T_DATA = '0;
    repeat (3) @(negedge clk);
    chk("reset_a_ctrl", {26'd0, ifa.MDC, ifa.MDIO_OE, ifa.MDIO_OUT, ifa.BUSY, ifa.DATA_RDY, ifa.RD_ERR}, 32'd0);
    chk("reset_a_rd_data", {16'd0, ifa.RD_DATA}, 32'd0);
    chk("reset_b_ctrl", {26'd0, ifb.MDC, ifb.MDIO_OE, ifb.MDIO_OUT, ifb.BUSY, ifb.DATA_RDY, ifb.RD_ERR}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // c22 write PHY3 REG4 0xBEEF
    issue(32'h5192BEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 32, 4);
    wait_idle("t1");
    // c22 read, clean turnaround
    issue(32'h61900000, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 32, 4);
    wait_idle("t2");
    // c22 read, PHY drives turnaround bit 2 high
    issue(32'h61900000, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b1, 32, 4);
    wait_idle("t3");
    // second read pattern so a later write is seen to hold a distinct value
    issue(32'h61900000, 1'b1, 1'b0, 16'hA5C3, 16'hA5C3, 1'b0, 32, 4);
    wait_idle("t3b");

    // write with START re-pulsed mid-frame and in the DATA_RDY cycle
    issue(32'h5192BEEF, 1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 32, 4);
    wait_rises("t5_mid", 10, 1'b0);
    drive_start(1'b1, 32'h6FFF0000);
    @(negedge clk);
    drive_start(1'b0, 32'h6FFF0000);
    n = 0;
    while (!m_rdy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rdy_timeout", {31'd0, n >= 3000}, 32'd0);
    drive_start(1'b1, 32'h61900000);
    @(negedge clk);
    drive_start(1'b0, 32'h61900000);
    wait_idle("t5");
    repeat (40) @(negedge clk);
    chk("t5_no_restart", {31'd0, m_busy}, 32'd0);

    // c45 address frame on the DIV=2, no-preamble instance
    sel = 1'b1;
    issue(32'h0D9000AA, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 2);
    wait_idle("t4");
    sel = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of the DATA phase
    issue(32'h5192BEEF, 1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 32, 4);
    wait_rises("t6_mid", 52, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_ctrl", {28'd0, ifa.MDC, ifa.MDIO_OE, ifa.MDIO_OUT, ifa.BUSY}, 32'd0);
    chk("t6_async_rd_data", {16'd0, ifa.RD_DATA}, 32'd0);
    bit_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h5192BEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 32, 4);
    wait_idle("t6_after");

    chk("queues_empty", 32'(exp_q.size() + bit_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
